// File: rtl/branch_resolve_predict.sv
// Branch resolution and bimodal direction prediction.
// EX-stage MIPS conditional branches are evaluated and the outcome registered
// one cycle later; a table of 2-bit saturating counters indexed by word PC
// supplies IF with a taken/not-taken guess, and saturating statistics
// counters record resolved branches and mispredicts.
module branch_resolve_predict #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              r_valid,
  input  logic [PC_W-1:0]   r_pc,
  input  logic [5:0]        r_op,
  input  logic [4:0]        r_rt,
  input  logic [DATA_W-1:0] r_a,
  input  logic [DATA_W-1:0] r_b,
  input  logic              r_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic is_branch;
  logic cond_taken;
  logic resolve;
  logic mispredict;
  logic a_zero;
  logic a_neg;
  logic a_eq_b;
  logic unused_pc_bits;

  assign a_zero     = (r_a == '0);
  assign a_neg      = r_a[DATA_W-1];
  assign a_eq_b     = (r_a == r_b);
  assign resolve    = r_valid & is_branch;
  assign mispredict = cond_taken ^ r_pred_taken;

  // Only the index bits of the PCs feed the table; the rest are deliberately dropped.
  assign unused_pc_bits = ^{f_pc, r_pc};

  // Decode the opcode/rt pair into "is a conditional branch" and its direction.
  always_comb begin
    is_branch  = 1'b0;
    cond_taken = 1'b0;
    case (r_op)
      OP_BEQ: begin
        is_branch  = 1'b1;
        cond_taken = a_eq_b;
      end
      OP_BNE: begin
        is_branch  = 1'b1;
        cond_taken = !a_eq_b;
      end
      OP_BGTZ: begin
        is_branch  = 1'b1;
        cond_taken = !a_neg && !a_zero;
      end
      OP_BLEZ: begin
        is_branch  = 1'b1;
        cond_taken = a_neg || a_zero;
      end
      OP_REGIMM: begin
        case (r_rt)
          RT_BGEZ, RT_BGEZAL: begin
            is_branch  = 1'b1;
            cond_taken = !a_neg;
          end
          RT_BLTZ, RT_BLTZAL: begin
            is_branch  = 1'b1;
            cond_taken = a_neg;
          end
          default: begin
            is_branch  = 1'b0;
            cond_taken = 1'b0;
          end
        endcase
      end
      default: begin
        is_branch  = 1'b0;
        cond_taken = 1'b0;
      end
    endcase
  end

  // Register the resolution; direction and mispredict read as 0 when nothing resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
    end else begin
      res_valid      <= resolve;
      res_taken      <= resolve & cond_taken;
      res_mispredict <= resolve & mispredict;
    end
  end

  // Saturating statistics: hold at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (resolve) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end

  generate
    if (PRED_MODE == 1) begin : g_bht
      logic [1:0]       bht [BHT_DEPTH];
      logic [IDX_W-1:0] f_idx;
      logic [IDX_W-1:0] r_idx;

      assign f_idx = f_pc[IDX_W+1:2];
      assign r_idx = r_pc[IDX_W+1:2];

      // Read-before-write: a same-index update this cycle is seen only after the edge.
      assign f_pred_taken = bht[f_idx][1];

      // Train the resolving branch's counter toward its actual direction.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < BHT_DEPTH; i++) begin
            bht[i] <= 2'b01;
          end
        end else if (resolve) begin
          if (cond_taken) begin
            if (bht[r_idx] != 2'b11) begin
              bht[r_idx] <= bht[r_idx] + 2'b01;
            end
          end else begin
            if (bht[r_idx] != 2'b00) begin
              bht[r_idx] <= bht[r_idx] - 2'b01;
            end
          end
        end
      end
    end else begin : g_static
      assign f_pred_taken = 1'b0;
    end
  endgenerate

endmodule
